// File: rtl/wl_cg_ctrl.sv
// Clock-gating controller: one ON/IDLE/OFF/WAKE FSM per gated domain with an
// idle hysteresis before gating, a fixed settle time after ungating, a global
// force-on override and a saturating count of gating events.
module wl_cg_ctrl #(
    parameter int CLK_NUM  = 1,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               force_on_i,
    input  logic [CLK_NUM-1:0] busy_i,
    input  logic [CLK_NUM-1:0] wake_req_i,
    output logic [CLK_NUM-1:0] cg_en_o,
    output logic [CLK_NUM-1:0] rdy_o,
    output logic [15:0]        gate_cnt_o
);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_e;

    localparam int MAX_CYC = (IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);

    state_e             state_q [CLK_NUM];
    state_e             state_d [CLK_NUM];
    logic [CNT_W-1:0]   cnt_q   [CLK_NUM];
    logic [CNT_W-1:0]   cnt_d   [CLK_NUM];
    logic [CLK_NUM-1:0] cg_en_q, cg_en_d;
    logic [CLK_NUM-1:0] rdy_q, rdy_d;
    logic [CLK_NUM-1:0] gate_ev;
    logic [CLK_NUM-1:0] act;
    logic [15:0]        gate_cnt_q, gate_cnt_d;
    logic [31:0]        n_gate;
    logic [31:0]        cnt_sum;

    // Any pending work, wake request or the global override keeps a domain alive.
    assign act = busy_i | wake_req_i | {CLK_NUM{force_on_i}};

    // Per-domain next state, hysteresis/settle counter and registered-output values.
    always_comb begin
        for (int k = 0; k < CLK_NUM; k++) begin
            // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            gate_ev[k] = 1'b0;
            case (state_q[k])
                ST_ON: begin
                    if (!act[k]) begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = IDLE_LD;
                    end
                end
                ST_IDLE: begin
                    if (act[k]) begin
                        state_d[k] = ST_ON;
                    end else if (cnt_q[k] != '0) begin
                        cnt_d[k] = cnt_q[k] - 1'b1;
                    end else begin
                        state_d[k] = ST_OFF;
                        gate_ev[k] = 1'b1;
                    end
                end
                ST_OFF: begin
                    if (act[k]) begin
                        state_d[k] = ST_WAKE;
                        cnt_d[k]   = WAKE_LD;
                    end
                end
                ST_WAKE: begin
                    // Settling is never aborted; only the counter decides.
                    if (cnt_q[k] != '0) begin
                        cnt_d[k] = cnt_q[k] - 1'b1;
                    end else begin
                        state_d[k] = ST_ON;
                    end
                end
                default: begin
                    state_d[k] = ST_ON;
                    cnt_d[k]   = '0;
                end
            endcase
            // Outputs are decoded from the next state so they can be registered.
            cg_en_d[k] = (state_d[k] != ST_OFF);
            rdy_d[k]   = (state_d[k] == ST_ON) || (state_d[k] == ST_IDLE);
        end
    end

    // Saturating accumulation of all gating events seen in this cycle.
    always_comb begin
        n_gate = '0;
        for (int k = 0; k < CLK_NUM; k++) begin
            n_gate = n_gate + {31'd0, gate_ev[k]};
        end
        cnt_sum    = {16'd0, gate_cnt_q} + n_gate;
        gate_cnt_d = (cnt_sum > 32'h0000_FFFF) ? 16'hFFFF : cnt_sum[15:0];
    end

    // State, counters and output flops; reset returns every domain to ON.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CLK_NUM; k++) begin
                state_q[k] <= ST_ON;
                cnt_q[k]   <= '0;
            end
            cg_en_q    <= '1;
            rdy_q      <= '1;
            gate_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            for (int k = 0; k < CLK_NUM; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            cg_en_q    <= cg_en_d;
            rdy_q      <= rdy_d;
            gate_cnt_q <= gate_cnt_d;
        end
    end

    assign cg_en_o    = cg_en_q;
    assign rdy_o      = rdy_q;
    assign gate_cnt_o = gate_cnt_q;

endmodule

// File: tb/tb_wl_cg_ctrl.sv
// Self-checking bench for wl_cg_ctrl: a 4-domain instance driven from a vector
// table through a scoreboard queue, plus a 16-domain instance with minimal
// hysteresis used to drive the gating counter into saturation.
module tb_wl_cg_ctrl;

    typedef struct {
        logic        f;
        logic [3:0]  b;
        logic [3:0]  w;
        logic [3:0]  cg;
        logic [3:0]  rdy;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [3:0]  cg;
        logic [3:0]  rdy;
        logic [15:0] cnt;
        int          idx;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        force_on;
    logic [3:0]  busy;
    logic [3:0]  wake;
    logic [3:0]  cg_en;
    logic [3:0]  rdy;
    logic [15:0] gate_cnt;

    logic [15:0] busy_s;
    logic [15:0] cg_en_s;
    logic [15:0] rdy_s;
    logic [15:0] gate_cnt_s;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    wl_cg_ctrl #(.CLK_NUM(4), .IDLE_CYC(4), .WAKE_CYC(2)) u_dut (
        .clk_i      (clk),
        .rst_n      (rst_n),
        .force_on_i (force_on),
        .busy_i     (busy),
        .wake_req_i (wake),
        .cg_en_o    (cg_en),
        .rdy_o      (rdy),
        .gate_cnt_o (gate_cnt)
    );

    wl_cg_ctrl #(.CLK_NUM(16), .IDLE_CYC(1), .WAKE_CYC(1)) u_sat (
        .clk_i      (clk),
        .rst_n      (rst_n),
        .force_on_i (1'b0),
        .busy_i     (busy_s),
        .wake_req_i (16'h0000),
        .cg_en_o    (cg_en_s),
        .rdy_o      (rdy_s),
        .gate_cnt_o (gate_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic f, input logic [3:0] b, input logic [3:0] w,
                       input logic [3:0] cg, input logic [3:0] r, input logic [15:0] c);
        vec_t v;
        v.f = f; v.b = b; v.w = w; v.cg = cg; v.rdy = r; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic f, input logic [3:0] b, input logic [3:0] w,
                         input logic [3:0] cg, input logic [3:0] r, input logic [15:0] c);
        for (int i = 0; i < n; i++) add(f, b, w, cg, r, c);
    endtask

    // Drive one vector before an edge, queue its expectation, compare after the edge.
    task automatic apply(input int idx);
        exp_t e;
        @(negedge clk);
        force_on = vecs[idx].f;
        busy     = vecs[idx].b;
        wake     = vecs[idx].w;
        e.cg = vecs[idx].cg; e.rdy = vecs[idx].rdy; e.cnt = vecs[idx].cnt; e.idx = idx;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("v%0d_cg_en", e.idx), 32'(cg_en), 32'(e.cg));
        check($sformatf("v%0d_rdy", e.idx), 32'(rdy), 32'(e.rdy));
        check($sformatf("v%0d_gate_cnt", e.idx), 32'(gate_cnt), 32'(e.cnt));
    endtask

    // One gating round on the 16-domain instance: masked domains idle, gate, wake, settle.
    task automatic sat_round(input logic [15:0] mask);
        @(negedge clk);
        busy_s = ~mask;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        busy_s = 16'hFFFF;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_post;
        rst_n    = 1'b1;
        force_on = 1'b0;
        busy     = 4'hF;
        wake     = 4'h0;
        busy_s   = 16'hFFFF;

        // Domain 0 idles: gates on the 5th idle edge.
        add_n(4, 0, 4'hE, 4'h0, 4'hF, 4'hF, 16'd0);
        add_n(2, 0, 4'hE, 4'h0, 4'hE, 4'hE, 16'd1);
        // Wake pulse: enable next edge, ready two edges later, busy low ignored.
        add  (0, 4'hE, 4'h1, 4'hF, 4'hE, 16'd1);
        add  (0, 4'hE, 4'h0, 4'hF, 4'hE, 16'd1);
        add  (0, 4'hE, 4'h0, 4'hF, 4'hF, 16'd1);
        // Busy pulse with IDLE counter at 1 restarts the full hysteresis.
        add_n(3, 0, 4'hE, 4'h0, 4'hF, 4'hF, 16'd1);
        add  (0, 4'hF, 4'h0, 4'hF, 4'hF, 16'd1);
        add_n(4, 0, 4'hE, 4'h0, 4'hF, 4'hF, 16'd1);
        add  (0, 4'hE, 4'h0, 4'hE, 4'hE, 16'd2);
        // Wake domain 0, then all four idle together and gate in the same cycle.
        add  (0, 4'hE, 4'h1, 4'hF, 4'hE, 16'd2);
        add  (0, 4'hE, 4'h0, 4'hF, 4'hE, 16'd2);
        add  (0, 4'hE, 4'h0, 4'hF, 4'hF, 16'd2);
        add_n(4, 0, 4'h0, 4'h0, 4'hF, 4'hF, 16'd2);
        add_n(2, 0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd6);
        // Force-on wakes all four and keeps them from gating.
        add_n(2, 1, 4'h0, 4'h0, 4'hF, 4'h0, 16'd6);
        add_n(6, 1, 4'h0, 4'h0, 4'hF, 4'hF, 16'd6);
        add_n(4, 0, 4'h0, 4'h0, 4'hF, 4'hF, 16'd6);
        add  (0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd10);
        // Enter WAKE on all domains; reset will land mid-sequence.
        add  (0, 4'h0, 4'hF, 4'hF, 4'h0, 16'd10);
        first_post = vecs.size();
        // After reset release: full hysteresis again from ON.
        add_n(4, 0, 4'h0, 4'h0, 4'hF, 4'hF, 16'd0);
        add  (0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd4);

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        check("rst_cg_en", 32'(cg_en), 32'hF);
        check("rst_rdy", 32'(rdy), 32'hF);
        check("rst_gate_cnt", 32'(gate_cnt), 32'h0);
        #19 rst_n = 1'b1;

        for (int i = 0; i < first_post; i++) apply(i);

        // Asynchronous reset between edges while every domain is in WAKE.
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_cg_en", 32'(cg_en), 32'hF);
        check("async_rst_rdy", 32'(rdy), 32'hF);
        check("async_rst_gate_cnt", 32'(gate_cnt), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = first_post; i < vecs.size(); i++) apply(i);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        // Saturation: 4095 x 16 + 14 events reach 0xFFFE, then two more saturate.
        force_on = 1'b0;
        busy     = 4'hF;
        for (int r = 0; r < 4095; r++) sat_round(16'hFFFF);
        sat_round(16'h3FFF);
        check("sat_preload", 32'(gate_cnt_s), 32'hFFFE);
        sat_round(16'h0003);
        check("sat_reach", 32'(gate_cnt_s), 32'hFFFF);
        sat_round(16'hFFFF);
        check("sat_hold", 32'(gate_cnt_s), 32'hFFFF);
        check("sat_cg_en_on", 32'(cg_en_s), 32'hFFFF);
        check("sat_rdy_on", 32'(rdy_s), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wl_cg_ctrl.md
WL_CG_CTRL -- requirements
Module: wl_cg_ctrl

Interface
REQ-001 SHALL have parameter CLK_NUM, default 1: number of gated clock domains controlled.
REQ-002 SHALL have parameter IDLE_CYC, default 16, legal range >=1: idle hysteresis before gating.
REQ-003 SHALL have parameter WAKE_CYC, default 2, legal range >=1: settle cycles after ungating before the domain is ready.
REQ-004 SHALL have port clk_i, input, 1: single controller clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port force_on_i, input, 1: global override (DFT/debug); keeps every domain ungated.
REQ-007 SHALL have port busy_i, input, CLK_NUM: per-domain activity, high = work pending.
REQ-008 SHALL have port wake_req_i, input, CLK_NUM: per-domain wake request pulse or level from upstream.
REQ-009 SHALL have port cg_en_o, input-to-gate, output, CLK_NUM: registered enable per domain, drives the clock-gate enable.
REQ-010 SHALL have port rdy_o, output, CLK_NUM: registered; high = domain clock running and settled.
REQ-011 SHALL have port gate_cnt_o, output, 16: count of ON-to-OFF gating events summed over all domains.

Function
REQ-012 SHALL run one independent FSM per domain k with states ON, IDLE, OFF, WAKE and a down-counter wide enough for max(IDLE_CYC, WAKE_CYC)-1.
REQ-013 SHALL define act[k] = busy_i[k] | wake_req_i[k] | force_on_i, sampled each rising edge.
REQ-014 ON: cg_en_o=1, rdy_o=1; act=0 -> IDLE with counter loaded IDLE_CYC-1; act=1 -> stay ON.
REQ-015 IDLE: cg_en_o=1, rdy_o=1; act=1 -> ON; act=0 and counter!=0 -> decrement; act=0 and counter==0 -> OFF.
REQ-016 cg_en_o[k] SHALL therefore fall on the edge sampling the (IDLE_CYC+1)th consecutive cycle with act[k]=0; any single act=1 restarts hysteresis.
REQ-017 OFF: cg_en_o=0, rdy_o=0; act=1 -> WAKE with counter loaded WAKE_CYC-1; otherwise stay OFF.
REQ-018 WAKE: cg_en_o=1, rdy_o=0; counter decrements each cycle regardless of act; counter==0 -> ON.
REQ-019 rdy_o[k] SHALL rise exactly WAKE_CYC cycles after cg_en_o[k] rises; WAKE is never aborted, even if act drops.
REQ-020 force_on_i=1 SHALL hold ON/IDLE domains in ON and move OFF domains to WAKE; no domain enters OFF while force_on_i=1.
REQ-021 cg_en_o and rdy_o SHALL be direct flop outputs (no combinational path from inputs), glitch-free per cycle.
REQ-022 gate_cnt_o SHALL add the number of domains taking IDLE->OFF in that cycle (0..CLK_NUM), saturating at 16'hFFFF.
REQ-023 Simultaneous IDLE->OFF in several domains SHALL all be counted in the same cycle.

Reset
REQ-024 On rst_n=0, asynchronously: all FSMs = ON, counters = 0, cg_en_o = all ones, rdy_o = all ones, gate_cnt_o = 0.
REQ-025 Reset asserted mid-WAKE or mid-IDLE SHALL abandon the sequence; after release domains start in ON with full hysteresis.

Verification
REQ-026 IDLE_CYC=4, busy_i[0] falls and stays low -> cg_en_o[0] and rdy_o[0] fall after 5 idle edges; gate_cnt_o 0->1.
REQ-027 Domain in IDLE with counter at 1, busy_i pulses high one cycle -> back to ON, next gating needs full 5 idle edges again.
REQ-028 WAKE_CYC=2, domain OFF, wake_req_i one-cycle pulse -> cg_en_o rises next edge, rdy_o rises 2 cycles later; busy_i low during WAKE does not abort.
REQ-029 CLK_NUM=4, all domains idle together -> all gate same cycle, gate_cnt_o increments by 4; force_on_i=1 then wakes all four.
REQ-030 gate_cnt_o preloaded near 16'hFFFE by long run, two domains gate together -> gate_cnt_o = 16'hFFFF, stays.
REQ-031 rst_n asserted mid-WAKE, asynchronously between edges -> cg_en_o=all ones, rdy_o=all ones, gate_cnt_o=0 immediately.
